// File: rtl/bm_accum_pkg.sv
// -----------------------------------------------------------------------------
// bm_accum_pkg
// Shared definitions for the product accumulator slice.
//   state_e          : accumulator FSM encoding (ACCUM collects, HOLD presents)
//   DEF_PROD_WIDTH   : default incoming product width
//   DEF_ACC_WIDTH    : default accumulator / result width
//   DEF_COUNT        : default number of products per batch
//   DEF_CNT_WIDTH    : default batch counter width
// -----------------------------------------------------------------------------
package bm_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned DEF_PROD_WIDTH = 16;
    localparam int unsigned DEF_ACC_WIDTH  = 24;
    localparam int unsigned DEF_COUNT      = 4;
    localparam int unsigned DEF_CNT_WIDTH  = 8;

endpackage : bm_accum_pkg

// File: rtl/bm_product_accumulator_if.sv
// -----------------------------------------------------------------------------
// bm_product_accumulator_if
// Groups the product input stream, the clear strobe and the result output
// stream of the product accumulator.
//   prod_in/prod_valid/prod_ready : product stream from the multiply stage
//   clear                         : discard the partial batch
//   sum_out/overflow/sum_valid/sum_ready : completed batch result stream
// Modports:
//   master : the surrounding system (drives products, consumes results)
//   slave  : the accumulator itself
// -----------------------------------------------------------------------------
interface bm_product_accumulator_if
    import bm_accum_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
);

    logic [PROD_WIDTH-1:0] prod_in;
    logic                  prod_valid;
    logic                  prod_ready;
    logic                  clear;
    logic [ACC_WIDTH-1:0]  sum_out;
    logic                  sum_valid;
    logic                  sum_ready;
    logic                  overflow;

    modport master (
        output prod_in,
        output prod_valid,
        output clear,
        output sum_ready,
        input  prod_ready,
        input  sum_out,
        input  sum_valid,
        input  overflow
    );

    modport slave (
        input  prod_in,
        input  prod_valid,
        input  clear,
        input  sum_ready,
        output prod_ready,
        output sum_out,
        output sum_valid,
        output overflow
    );

endinterface : bm_product_accumulator_if

// File: rtl/bm_batch_counter.sv
// -----------------------------------------------------------------------------
// bm_batch_counter
// Counts accepted products within a batch.
//   clock    : clock, state updates on posedge
//   reset    : synchronous active-high reset
//   inc      : advance the count by one
//   clr      : return the count to zero (wins over inc)
//   terminal : count has reached COUNT-1, the next product closes the batch
// -----------------------------------------------------------------------------
module bm_batch_counter
    import bm_accum_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int unsigned COUNT     = DEF_COUNT
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic terminal
);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign terminal = (count_q == CNT_WIDTH'(COUNT - 1));

endmodule : bm_batch_counter

// File: rtl/bm_product_accumulator.sv
// -----------------------------------------------------------------------------
// bm_product_accumulator
// Sums COUNT unsigned products into an ACC_WIDTH result (wrapping), then
// presents the result on a valid/ready handshake. While a result is pending
// no further products are taken; after the result is consumed there is one
// bubble cycle before products are accepted again.
//   clock : clock, all state updates on posedge
//   reset : synchronous active-high reset
//   bus   : slave side of bm_product_accumulator_if
//           prod_in/prod_valid/prod_ready, clear,
//           sum_out/overflow/sum_valid/sum_ready
// -----------------------------------------------------------------------------
module bm_product_accumulator
    import bm_accum_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned COUNT      = DEF_COUNT,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    bm_product_accumulator_if.slave bus
);

    state_e               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_acc_q;
    logic [ACC_WIDTH-1:0] sum_q;
    logic                 sum_valid_q;
    logic                 overflow_q;

    logic                 prod_ready;
    logic                 accept;
    logic                 terminal;
    logic                 cnt_inc;
    logic                 cnt_clr;
    logic [ACC_WIDTH:0]   add_full;
    logic                 carry;

    // The only combinational input-to-output path.
    assign prod_ready = (state_q == ACCUM) && !bus.clear && !reset;
    assign accept     = bus.prod_valid && prod_ready;

    // One extra bit captures the carry out of the accumulator.
    assign add_full = {1'b0, acc_q} + {{(ACC_WIDTH - PROD_WIDTH + 1){1'b0}}, bus.prod_in};
    assign carry    = add_full[ACC_WIDTH];

    // clear only acts in ACCUM; in HOLD the counter is already zero.
    assign cnt_inc = accept && !terminal;
    assign cnt_clr = ((state_q == ACCUM) && bus.clear) || (accept && terminal);

    bm_batch_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .COUNT     (COUNT)
    ) u_batch_counter (
        .clock    (clock),
        .reset    (reset),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .terminal (terminal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.clear) begin
                        acc_q     <= '0;
                        ovf_acc_q <= 1'b0;
                    end else if (accept) begin
                        if (terminal) begin
                            sum_q       <= add_full[ACC_WIDTH-1:0];
                            overflow_q  <= ovf_acc_q | carry;
                            sum_valid_q <= 1'b1;
                            acc_q       <= '0;
                            ovf_acc_q   <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            acc_q     <= add_full[ACC_WIDTH-1:0];
                            ovf_acc_q <= ovf_acc_q | carry;
                        end
                    end
                end
                HOLD: begin
                    // Result stays put until taken; clear is ignored here.
                    if (sum_valid_q && bus.sum_ready) begin
                        sum_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.sum_out    = sum_q;
    assign bus.sum_valid  = sum_valid_q;
    assign bus.overflow   = overflow_q;

endmodule : bm_product_accumulator
